comparator_operand_sequencer: RTL and testbench

//  - Upstream control stage for the (n+1)-bit power-gated magnitude comparator.
//  - Accepts operand pairs over a valid/ready handshake and presents them to the comparator.
//  - Generates the comparator's enable rising edge and reset, waits a fixed settle window, then registers the flags.
//  - Returns one result per operand pair over a valid/ready handshake. The comparator stays gated (enable low) while idle.

---
 rtl/cmp_seq_pkg.sv | 22 ++
 rtl/comparator_operand_sequencer_if.sv | 24 ++
 rtl/cmp_settle_timer.sv | 31 +++
 rtl/comparator_operand_sequencer.sv | 123 ++++++++++++
 tb/tb_comparator_operand_sequencer.sv | 284 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/cmp_seq_pkg.sv
// Shared definitions for the comparator operand sequencer: state encoding,
// flag-vector bit positions and settle-counter width.
package cmp_seq_pkg;

  localparam int unsigned CNT_W   = 8;
  localparam int unsigned FLAG_LT = 2;
  localparam int unsigned FLAG_EQ = 1;
  localparam int unsigned FLAG_GT = 0;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD   = 3'd1,
    ST_ARM    = 3'd2,
    ST_SETTLE = 3'd3,
    ST_RESULT = 3'd4
  } state_e;

  function automatic logic is_one_hot3(input logic [2:0] v);
    return (v == 3'b001) || (v == 3'b010) || (v == 3'b100);
  endfunction

endpackage

// File: rtl/comparator_operand_sequencer_if.sv
// Operand-in / result-out handshake bundle of the comparator operand sequencer.
interface comparator_operand_sequencer_if #(
  parameter int unsigned N = 3
);
  logic         in_valid;
  logic         in_ready;
  logic [N:0]   a_in;
  logic [N:0]   b_in;
  logic         out_valid;
  logic         out_ready;
  logic         less_than;
  logic         equal_to;
  logic         greater_than;

  modport master (
    output in_valid, a_in, b_in, out_ready,
    input  in_ready, out_valid, less_than, equal_to, greater_than
  );

  modport slave (
    input  in_valid, a_in, b_in, out_ready,
    output in_ready, out_valid, less_than, equal_to, greater_than
  );
endinterface

// File: rtl/cmp_settle_timer.sv
// Settle-window down counter: loads a start value, decrements on request,
// reports zero.
module cmp_settle_timer
  import cmp_seq_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             dec,
  input  logic [CNT_W-1:0] load_val,
  output logic             zero
);

  logic [CNT_W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (load)
      count_d = load_val;
    else if (dec && (count_q != '0))
      count_d = count_q - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) count_q <= '0;
    else       count_q <= count_d;
  end

  assign zero = (count_q == '0);

endmodule

// File: rtl/comparator_operand_sequencer.sv
// Sequences operand pairs into a power-gated magnitude comparator and returns
// registered flags. Optional flag one-hot check: define CMP_FLAG_CHECK_EN.
module comparator_operand_sequencer
  import cmp_seq_pkg::*;
#(
  parameter int unsigned n             = 3,
  parameter int unsigned SETTLE_CYCLES = n + 2
) (
  input  logic                                 clk,
  input  logic                                 reset,
  comparator_operand_sequencer_if.slave        bus,
  output logic                                 cmp_enable,
  output logic                                 cmp_reset,
  output logic [n:0]                           cmp_a,
  output logic [n:0]                           cmp_b,
  input  logic                                 cmp_less,
  input  logic                                 cmp_equal,
  input  logic                                 cmp_greater,
  output logic                                 busy,
  output logic                                 flag_err
);

  state_e     state_q, state_d;
  logic [n:0] cmp_a_q, cmp_a_d, cmp_b_q, cmp_b_d;
  logic [2:0] flags_q, flags_d;
  logic [2:0] cmp_flags;
  logic       accept, sample, timer_zero;
  logic       in_ready_o, out_valid_o;

  assign cmp_flags = {cmp_less, cmp_equal, cmp_greater};
  assign accept    = (state_q == ST_IDLE) && bus.in_valid;
  assign sample    = (state_q == ST_SETTLE) && timer_zero;

  cmp_settle_timer u_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (state_q == ST_ARM),
    .dec      (state_q == ST_SETTLE),
    .load_val (CNT_W'(SETTLE_CYCLES - 1)),
    .zero     (timer_zero)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cmp_a_q <= '0;
      cmp_b_q <= '0;
      flags_q <= '0;
    end else begin
      state_q <= state_d;
      cmp_a_q <= cmp_a_d;
      cmp_b_q <= cmp_b_d;
      flags_q <= flags_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:   if (accept) state_d = ST_LOAD;
      ST_LOAD:   state_d = ST_ARM;
      ST_ARM:    state_d = ST_SETTLE;
      ST_SETTLE: if (timer_zero) state_d = ST_RESULT;
      ST_RESULT: if (bus.out_ready) state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    cmp_a_d = accept ? bus.a_in : cmp_a_q;
    cmp_b_d = accept ? bus.b_in : cmp_b_q;
    flags_d = sample ? cmp_flags : flags_q;
  end

  // Reset overrides the state decode so nothing leaks out during the reset cycle.
  always_comb begin
    in_ready_o  = 1'b0;
    out_valid_o = 1'b0;
    cmp_enable  = 1'b0;
    cmp_reset   = 1'b0;
    busy        = 1'b0;
    if (reset) begin
      cmp_reset = 1'b1;
    end else begin
      unique case (state_q)
        ST_IDLE:   in_ready_o = 1'b1;
        ST_LOAD:   begin cmp_reset = 1'b1; busy = 1'b1; end
        ST_ARM:    begin cmp_enable = 1'b1; busy = 1'b1; end
        ST_SETTLE: begin cmp_enable = 1'b1; busy = 1'b1; end
        ST_RESULT: begin out_valid_o = 1'b1; busy = 1'b1; end
        default:   ;
      endcase
    end
  end

`ifdef CMP_FLAG_CHECK_EN
  logic flag_err_q, flag_err_d;

  always_comb begin
    flag_err_d = flag_err_q;
    if (sample && !is_one_hot3(cmp_flags))
      flag_err_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) flag_err_q <= 1'b0;
    else       flag_err_q <= flag_err_d;
  end

  assign flag_err = flag_err_q;
`else
  assign flag_err = 1'b0;
`endif

  assign cmp_a            = cmp_a_q;
  assign cmp_b            = cmp_b_q;
  assign bus.in_ready     = in_ready_o;
  assign bus.out_valid    = out_valid_o;
  assign bus.less_than    = flags_q[FLAG_LT];
  assign bus.equal_to     = flags_q[FLAG_EQ];
  assign bus.greater_than = flags_q[FLAG_GT];

endmodule

// File: tb/tb_comparator_operand_sequencer.sv
// Scoreboard bench for comparator_operand_sequencer with a behavioural
// comparator model and randomized operand traffic.
module tb_comparator_operand_sequencer;

  localparam int unsigned N = 3;
  localparam int unsigned S = N + 2;
`ifdef CMP_FLAG_CHECK_EN
  localparam logic EXP_ERR = 1'b1;
`else
  localparam logic EXP_ERR = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  comparator_operand_sequencer_if #(.N(N)) bus();

  logic       cmp_enable, cmp_reset, busy, flag_err;
  logic       cmp_less, cmp_equal, cmp_greater;
  logic [N:0] cmp_a, cmp_b;
  logic       force_bad;
  logic       rand_ready;

  comparator_operand_sequencer #(.n(N), .SETTLE_CYCLES(S)) dut (
    .clk         (clk),
    .reset       (reset),
    .bus         (bus),
    .cmp_enable  (cmp_enable),
    .cmp_reset   (cmp_reset),
    .cmp_a       (cmp_a),
    .cmp_b       (cmp_b),
    .cmp_less    (cmp_less),
    .cmp_equal   (cmp_equal),
    .cmp_greater (cmp_greater),
    .busy        (busy),
    .flag_err    (flag_err)
  );

  // Comparator model: gated outputs are all low; a fault mode drives less and greater together.
  always_comb begin
    cmp_less    = 1'b0;
    cmp_equal   = 1'b0;
    cmp_greater = 1'b0;
    if (force_bad) begin
      cmp_less    = 1'b1;
      cmp_greater = 1'b1;
    end else if (cmp_enable) begin
      cmp_less    = cmp_a < cmp_b;
      cmp_equal   = cmp_a == cmp_b;
      cmp_greater = cmp_a > cmp_b;
    end
  end

  int unsigned passed = 0;
  int unsigned total  = 0;
  int unsigned cyc    = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [2:0]  flags;
    int unsigned t;
  } exp_t;
  exp_t sbq[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Monitor: checks results against the scoreboard, latency, post-result idle, operand stability.
  logic        ov_prev = 1'b0, en_prev = 1'b0, pend_idle = 1'b0;
  logic [N:0]  a_prev, b_prev;
  int unsigned rise_cyc = 0;

  always @(negedge clk) begin
    if (reset) begin
      ov_prev   = 1'b0;
      en_prev   = 1'b0;
      pend_idle = 1'b0;
    end else begin
      if (pend_idle) begin
        check("in_ready_after_result", bus.in_ready, 1);
        check("out_valid_after_result", bus.out_valid, 0);
        pend_idle = 1'b0;
      end
      if (bus.out_valid && !ov_prev) rise_cyc = cyc;
      if (cmp_enable && en_prev) begin
        check("cmp_a_stable", cmp_a, a_prev);
        check("cmp_b_stable", cmp_b, b_prev);
      end
      if (bus.out_valid && bus.out_ready) begin
        check("result_expected", sbq.size() != 0, 1);
        if (sbq.size() != 0) begin
          exp_t e;
          e = sbq.pop_front();
          check("result_flags", {bus.less_than, bus.equal_to, bus.greater_than}, e.flags);
          check("result_latency", rise_cyc - e.t, 3 + S);
        end
        pend_idle = 1'b1;
      end
      ov_prev = bus.out_valid;
      en_prev = cmp_enable;
      a_prev  = cmp_a;
      b_prev  = cmp_b;
    end
  end

  initial begin : ready_driver
    forever begin
      @(posedge clk);
      #1;
      if (rand_ready) bus.out_ready = ($urandom % 3) != 0;
    end
  end

  // Called just after a posedge; returns just after the accepting posedge, in_valid left high.
  task automatic send(input logic [N:0] a, input logic [N:0] b);
    exp_t e;
    bit   done = 0;
    bus.in_valid = 1'b1;
    bus.a_in     = a;
    bus.b_in     = b;
    for (int i = 0; i < 400 && !done; i++) begin
      @(negedge clk);
      if (bus.in_ready) begin
        e.flags = force_bad ? 3'b101 : {a < b, a == b, a > b};
        e.t     = cyc;
        sbq.push_back(e);
        done = 1;
      end
      @(posedge clk);
      #1;
    end
    if (!done) check("accept_timeout", 0, 1);
  endtask

  task automatic drain();
    for (int i = 0; i < 800 && sbq.size() != 0; i++) @(negedge clk);
    check("drain", sbq.size(), 0);
    @(posedge clk);
    #1;
  endtask

  initial begin : timeout
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin : stimulus
    logic [2:0] held;
    bit         seen;
    reset        = 1'b1;
    bus.in_valid = 1'b0;
    bus.a_in     = '0;
    bus.b_in     = '0;
    bus.out_ready = 1'b1;
    rand_ready   = 1'b0;
    force_bad    = 1'b0;

    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready", bus.in_ready, 0);
    check("rst_cmp_reset", cmp_reset, 1);
    check("rst_cmp_enable", cmp_enable, 0);
    check("rst_cmp_ab", {cmp_a, cmp_b}, 0);
    check("rst_out", {bus.out_valid, bus.less_than, bus.equal_to, bus.greater_than, busy, flag_err}, 0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    check("post_rst_in_ready", bus.in_ready, 1);
    check("post_rst_cmp_reset", cmp_reset, 0);
    @(posedge clk);
    #1;

    // Directed pairs: LT, EQ, GT.
    send(5, 9);
    bus.in_valid = 1'b0;
    drain();
    send(12, 12);
    bus.in_valid = 1'b0;
    drain();
    send(15, 0);
    bus.in_valid = 1'b0;
    drain();

    // Abort mid-settle.
    send(5, 9);
    bus.in_valid = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    check("abort_in_settle", cmp_enable, 1);
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(negedge clk);
    check("abort_rst_out_valid", bus.out_valid, 0);
    check("abort_rst_enable", cmp_enable, 0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    sbq.delete();
    @(negedge clk);
    check("abort_idle", {busy, cmp_enable, bus.out_valid, bus.in_ready}, 4'b0001);
    repeat (12) @(posedge clk);
    #1;

    // Backpressure: result held, no new pair accepted.
    bus.out_ready = 1'b0;
    send(3, 7);
    bus.a_in = 9;
    bus.b_in = 9;
    seen = 0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge clk);
      seen = bus.out_valid;
    end
    check("bp_out_valid_seen", seen, 1);
    held = {bus.less_than, bus.equal_to, bus.greater_than};
    check("bp_flags", held, 3'b100);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("bp_hold_valid", bus.out_valid, 1);
      check("bp_hold_flags", {bus.less_than, bus.equal_to, bus.greater_than}, held);
      check("bp_in_ready", bus.in_ready, 0);
      check("bp_gated", cmp_enable, 0);
    end
    @(posedge clk);
    #1;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    drain();

    // Back-to-back with in_valid held.
    send(1, 2);
    send(2, 1);
    send(0, 0);
    bus.in_valid = 1'b0;
    drain();

    // Randomized traffic with random backpressure.
    rand_ready = 1'b1;
    for (int i = 0; i < 25; i++) begin
      send(N'($urandom), N'($urandom));
      if ($urandom % 2) begin
        bus.in_valid = 1'b0;
        repeat ($urandom % 4) @(posedge clk);
        #1;
      end
    end
    bus.in_valid = 1'b0;
    drain();
    rand_ready = 1'b0;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b1;

    // Non-one-hot comparator flags.
    check("flag_err_clear", flag_err, 0);
    force_bad = 1'b1;
    send(2, 3);
    bus.in_valid = 1'b0;
    drain();
    force_bad = 1'b0;
    check("flag_err_set", flag_err, EXP_ERR);
    send(4, 4);
    bus.in_valid = 1'b0;
    drain();
    check("flag_err_sticky", flag_err, EXP_ERR);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    check("flag_err_reset", flag_err, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
